// File: rtl/md_block_copier.sv
// md_block_copier: copies a block of words between data-memory regions
// using absolute addressing, restoring the caller's relocation shift after.
module md_block_copier #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] length,
  input  logic [ADDR_W-1:0] return_shift,
  input  logic [DATA_W-1:0] md_read,
  output logic [ADDR_W-1:0] md_address,
  output logic [DATA_W-1:0] md_data,
  output logic              md_we,
  output logic [1:0]        md_flagShift,
  output logic [ADDR_W-1:0] md_shift,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE, SETUP, READ, CAPTURE, WRITE, RESTORE, DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] src, dst, len, rshift, idx;
  logic [ADDR_W-1:0] idx_nx;
  logic [DATA_W-1:0] word;

  assign idx_nx = idx + ADDR_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      src    <= '0;
      dst    <= '0;
      len    <= '0;
      rshift <= '0;
      idx    <= '0;
      word   <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            src    <= src_base;
            dst    <= dst_base;
            len    <= length;
            rshift <= return_shift;
            idx    <= '0;
          end
        end
        CAPTURE: word <= md_read;
        WRITE:   idx  <= idx_nx;
        default: ;
      endcase
    end
  end

  // Outputs depend only on registered state, never on the inputs.
  always_comb begin
    state_nx     = state;
    md_address   = '0;
    md_data      = '0;
    md_we        = 1'b0;
    md_flagShift = 2'd0;
    md_shift     = '0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = SETUP;
      end
      SETUP: begin
        busy         = 1'b1;
        md_flagShift = 2'd1;
        state_nx     = (len == '0) ? RESTORE : READ;
      end
      READ: begin
        busy       = 1'b1;
        md_address = src + idx;
        state_nx   = CAPTURE;
      end
      CAPTURE: begin
        busy       = 1'b1;
        md_address = src + idx;
        state_nx   = WRITE;
      end
      WRITE: begin
        busy       = 1'b1;
        md_address = dst + idx;
        md_data    = word;
        md_we      = 1'b1;
        state_nx   = (idx_nx == len) ? RESTORE : READ;
      end
      RESTORE: begin
        busy         = 1'b1;
        md_flagShift = 2'd2;
        md_shift     = rshift;
        state_nx     = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_md_block_copier.sv
// tb_md_block_copier: table-driven copies against a reference memory,
// with a write scoreboard plus start-while-busy and mid-copy reset cases.
module tb_md_block_copier;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [11:0] src_base, dst_base, length, return_shift;
  logic [31:0] md_read, md_data;
  logic [11:0] md_address, md_shift;
  logic        md_we, busy, done;
  logic [1:0]  md_flagShift;

  logic [31:0] mem [4096];
  logic [31:0] ref_mem [4096];
  logic        init_req = 1'b0;

  typedef struct {
    logic [11:0] src;
    logic [11:0] dst;
    logic [11:0] len;
    logic [11:0] rs;
    int          intrude;
  } vec_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  vec_t vecs[5];
  int   n_cmp = 0, n_err = 0;
  int   we_cnt = 0, done_cnt = 0;

  md_block_copier #(.ADDR_W(12), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .start(start),
    .src_base(src_base), .dst_base(dst_base),
    .length(length), .return_shift(return_shift),
    .md_read(md_read), .md_address(md_address),
    .md_data(md_data), .md_we(md_we),
    .md_flagShift(md_flagShift), .md_shift(md_shift),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  assign md_read = mem[md_address];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // memory model: write lands at the edge ending the WRITE cycle
  always @(posedge clock) begin
    if (init_req) begin
      for (int a = 0; a < 4096; a++) mem[a] = 32'(a + 1);
    end else if (md_we) begin
      mem[md_address] = md_data;
    end
  end

  // scoreboard side: writes checked mid-cycle
  always @(negedge clock) begin
    if (done) done_cnt++;
    if (md_we) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        chk("write_extra", 32'(md_address), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(md_address), 32'(e.addr));
        chk("wr_data", md_data, e.data);
      end
    end
  end

  task automatic init_mem();
    init_req = 1'b1;
    @(posedge clock);
    #1 init_req = 1'b0;
    for (int a = 0; a < 4096; a++) ref_mem[a] = 32'(a + 1);
    exp_q.delete();
  endtask

  task automatic plan(input vec_t v);
    logic [11:0] si, di;
    for (int i = 0; i < int'(v.len); i++) begin
      si = v.src + 12'(i);
      di = v.dst + 12'(i);
      ref_mem[di] = ref_mem[si];
      exp_q.push_back('{addr: di, data: ref_mem[di]});
    end
  endtask

  task automatic kick(input vec_t v);
    @(negedge clock);
    start = 1'b1;
    src_base = v.src;
    dst_base = v.dst;
    length = v.len;
    return_shift = v.rs;
    @(posedge clock);
    #1;
    start = 1'b0;
    src_base = 12'hAAA;
    dst_base = 12'h555;
    length = 12'h00F;
    return_shift = 12'h3C3;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n, we0, dn0, bad;
    logic [1:0]  pf;
    logic [11:0] ps;
    init_mem();
    plan(v);
    we0 = we_cnt;
    dn0 = done_cnt;
    kick(v);
    n = 0;
    pf = 2'd0;
    ps = 12'd0;
    @(negedge clock);
    chk({nm, "_setup_flag"}, 32'(md_flagShift), 32'd1);
    chk({nm, "_setup_busy"}, 32'(busy), 32'd1);
    while (!done && n < 60) begin
      if (n == v.intrude) begin
        start = 1'b1;
        src_base = 12'h500;
        dst_base = 12'h600;
        length = 12'd2;
        return_shift = 12'hABC;
      end
      pf = md_flagShift;
      ps = md_shift;
      @(posedge clock);
      #1 start = 1'b0;
      n++;
      @(negedge clock);
    end
    chk({nm, "_done_edges"}, 32'(n), 32'(2 + 3 * int'(v.len)));
    chk({nm, "_restore_flag"}, 32'(pf), 32'd2);
    chk({nm, "_restore_shift"}, 32'(ps), 32'(v.rs));
    chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
    repeat (4) @(negedge clock);
    chk({nm, "_done_pulses"}, 32'(done_cnt - dn0), 32'd1);
    chk({nm, "_we_pulses"}, 32'(we_cnt - we0), 32'(v.len));
    chk({nm, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
    bad = 0;
    for (int a = 0; a < 4096; a++) if (mem[a] !== ref_mem[a]) bad++;
    chk({nm, "_mem_bad_words"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int we0;
    vec_t rv;
    vecs[0] = '{12'h010, 12'h100, 12'd4, 12'h200, -1};
    vecs[1] = '{12'h020, 12'h300, 12'd0, 12'h055, -1};
    vecs[2] = '{12'hFFE, 12'h7FF, 12'd3, 12'h000, -1};
    vecs[3] = '{12'h040, 12'h140, 12'd4, 12'h123, 6};
    vecs[4] = '{12'h000, 12'h001, 12'd3, 12'h001, -1};

    reset = 1'b1;
    start = 1'b0;
    src_base = '0;
    dst_base = '0;
    length = '0;
    return_shift = '0;
    #12;
    chk("rst_address", 32'(md_address), 32'd0);
    chk("rst_data", md_data, 32'd0);
    chk("rst_we", 32'(md_we), 32'd0);
    chk("rst_flag", 32'(md_flagShift), 32'd0);
    chk("rst_shift", 32'(md_shift), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int k = 0; k < 5; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // reset while word 2 sits in CAPTURE
    rv = '{12'h080, 12'h180, 12'd4, 12'h077, -1};
    init_mem();
    plan(rv);
    we0 = we_cnt;
    kick(rv);
    @(negedge clock);
    repeat (8) begin
      @(posedge clock);
      @(negedge clock);
    end
    chk("mid_busy_before", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_we", 32'(md_we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_flag", 32'(md_flagShift), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    chk("mid_we_pulses", 32'(we_cnt - we0), 32'd2);
    chk("mid_word0", mem[12'h180], 32'h0000_0081);
    chk("mid_word1", mem[12'h181], 32'h0000_0082);
    chk("mid_word2", mem[12'h182], 32'h0000_0183);
    repeat (2) @(negedge clock);

    run_vec(vecs[0], "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_block_copier.md
# md_block_copier

Initiator-side engine for the data memory: it copies a block of 32-bit words from one data-memory region to another, for example when the SO loads a process image or relocates a process. It drives the data memory's address, write data, write enable and relocation-shift controls, and reads the memory's output word. Transfers use absolute addressing: the copier zeroes the relocation shift at the start of a transfer and restores a caller-supplied shift at the end. It sits beside the control unit and owns the data-memory port only while `busy` is high; an external mux selects its outputs during that time.

## Interface
Parameters:
- ADDR_W, 12, data-memory address width.
- DATA_W, 32, data-memory word width.

Ports:
- clock  in  1  system clock; every register updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  single-cycle request; sampled only in IDLE.
- src_base  in  ADDR_W  absolute source start address; sampled with `start`.
- dst_base  in  ADDR_W  absolute destination start address; sampled with `start`.
- length  in  ADDR_W  word count, 0..4095; sampled with `start`.
- return_shift  in  ADDR_W  relocation shift restored at the end; sampled with `start`.
- md_read  in  DATA_W  data-memory read word for `md_address`; valid by the next posedge of `clock`.
- md_address  out  ADDR_W  data-memory address.
- md_data  out  DATA_W  data-memory write word.
- md_we  out  1  data-memory write enable.
- md_flagShift  out  2  shift control: 0 = hold, 1 = zero shift, 2 = load `md_shift`.
- md_shift  out  ADDR_W  shift value loaded when `md_flagShift` = 2.
- busy  out  1  high while the engine owns the memory port.
- done  out  1  one-cycle pulse when a transfer completes.

## Operation
- States: IDLE, SETUP, READ, CAPTURE, WRITE, RESTORE, DONE.
- IDLE:
  - All outputs are 0.
  - If `start` = 1, latch `src_base`, `dst_base`, `length` and `return_shift`, clear index `i`, then go to SETUP.
- SETUP:
  - Drive `md_flagShift` = 1, so the memory's shift is 0 from the next edge.
  - Go to RESTORE if `length` = 0; otherwise go to READ.
- READ:
  - `md_address` = src + i, `md_we` = 0.
  - Go to CAPTURE.
- CAPTURE:
  - `md_address` holds src + i.
  - At the edge, latch `md_read` into the word buffer, then go to WRITE.
- WRITE:
  - `md_address` = dst + i, `md_data` = buffer, `md_we` = 1.
  - At the edge, i <= i + 1.
  - Go to RESTORE if i + 1 = `length`; otherwise go to READ.
- RESTORE:
  - Drive `md_flagShift` = 2 and `md_shift` = latched `return_shift`.
  - Go to DONE.
- DONE:
  - `done` = 1, `busy` = 0.
  - Go to IDLE.
- `busy` = 1 in SETUP through RESTORE; 0 in IDLE and DONE.
- Address arithmetic is modulo 2^ADDR_W; src + i and dst + i wrap from 4095 to 0.
- The copy always runs in ascending order. There is no overlap protection: if dst lies in (src, src+length), the destination receives already-overwritten source words. This is the defined behaviour.
- `start` outside IDLE is ignored; the latched parameters do not change.
- `md_data` = 0 and `md_shift` = 0 in every state where they are not used.
- `md_flagShift` = 0 in every state except SETUP and RESTORE.

## Timing
- All outputs are decoded from registered state; there are no combinational paths from inputs to outputs.
- `start` high at edge k: SETUP occupies cycle k+1.
- Each word costs 3 cycles (READ, CAPTURE, WRITE).
- For N ≥ 1: RESTORE falls in cycle k+2+3N and the `done` pulse in cycle k+3+3N.
- For N = 0: RESTORE at k+2, `done` at k+3, and `md_we` never asserts.
- The write for word i happens at the edge that ends its WRITE cycle.
- A new `start` is accepted in the cycle after DONE at the earliest.
- Reset:
  - Asserting `reset` at any time immediately forces IDLE and drops `md_we`, `busy`, `done` and `md_flagShift` to 0, without waiting for a clock edge.
  - Reset mid-transfer leaves the memory partially written and leaves the relocation shift at 0. The caller must reprogram the shift.
- Reset values: every output is 0; the index and the buffer are 0.

## Test plan
- Basic copy:
  - Stimulus: preload mem[0x010..0x013] = A0,A1,A2,A3; start with src=0x010, dst=0x100, len=4, return_shift=0x200.
  - Required response: mem[0x100..0x103] = A0..A3; `done` exactly 14 cycles after the `start` edge; `md_flagShift` = 2 with `md_shift` = 0x200 in the cycle before `done`; the source region is unchanged.
- Zero length:
  - Stimulus: len=0.
  - Required response: no `md_we` pulse; `md_flagShift` sequence 1 then 2; `done` at k+3.
- Wrap-around:
  - Stimulus: src=0xFFE, dst=0x7FF, len=3.
  - Required response: reads from 0xFFE, 0xFFF, 0x000; writes to 0x7FF, 0x800, 0x801 with the matching words.
- Start while busy:
  - Stimulus: pulse `start` with different parameters during the WRITE state of word 1 of a 4-word copy.
  - Required response: the original copy completes unchanged; one `done` pulse only.
- Reset mid-operation:
  - Stimulus: assert `reset` between edges during the CAPTURE state of word 2.
  - Required response: `md_we`, `busy` and `md_flagShift` go to 0 before the next edge; words 0..1 are written, word 2 is not; after release, a new copy runs normally.
- Overlapping forward copy:
  - Stimulus: mem[0..3] = 1,2,3,4; src=0, dst=1, len=3.
  - Required response: mem[0..3] = 1,1,1,1.
